regfile_wb_ctrl: RTL and testbench

//  Write-side initiator for the 32x32 register file: buffers writeback requests from the pipeline in a

---
 rtl/regfile_wb_ctrl_pkg.sv | 21 ++
 rtl/wb_fwd_match.sv | 62 ++++++
 rtl/regfile_wb_ctrl.sv | 179 +++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_pkg
//   Shared constants for the register-file writeback controller:
//     DEF_WIDTH / DEF_ADDR_W / DEF_DEPTH : default parameter values
//     R0_ADDR                            : hard-wired zero register address
//   Queue entries travel between the controller and the match logic as
//   packed words laid out {wa, wd}; entry_w() gives the width of one entry.
// ---------------------------------------------------------------------------
package regfile_wb_ctrl_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 4;
    localparam int R0_ADDR    = 0;

    // Width of one packed queue entry {wa, wd}.
    function automatic int entry_w(input int width, input int addr_w);
        return width + addr_w;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// ---------------------------------------------------------------------------
// wb_fwd_match
//   Youngest-first priority match of one read address against the
//   writeback queue. Purely combinational.
//   Ports:
//     ra          in   read address (r0 never matches)
//     head_ptr    in   slot index of the oldest queued entry
//     entry_valid in   per-slot occupied bits
//     entries     in   all slots packed, slot i at [i*ENTRY_W +: ENTRY_W],
//                      each entry laid out {wa, wd}
//     hit         out  some occupied slot holds ra
//     data        out  write data of the youngest matching slot (0 if none)
// ---------------------------------------------------------------------------
module wb_fwd_match
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic [ADDR_W-1:0]                 ra,
    input  logic [$clog2(DEPTH)-1:0]          head_ptr,
    input  logic [DEPTH-1:0]                  entry_valid,
    input  logic [DEPTH*(ADDR_W+WIDTH)-1:0]   entries,
    output logic                              hit,
    output logic [WIDTH-1:0]                  data
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = entry_w(WIDTH, ADDR_W);

    logic [WIDTH-1:0] slot_wd [DEPTH];
    logic [DEPTH-1:0] slot_match;
    logic [PTR_W-1:0] slot_idx;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [ADDR_W-1:0] slot_wa;
            assign slot_wa        = entries[gi*ENTRY_W + WIDTH +: ADDR_W];
            assign slot_wd[gi]    = entries[gi*ENTRY_W +: WIDTH];
            assign slot_match[gi] = entry_valid[gi] && (slot_wa == ra)
                                    && (ra != ADDR_W'(R0_ADDR));
        end
    endgenerate

    // Walk slots oldest to youngest; a later hit overrides an earlier one so
    // the youngest queued write to the register wins.
    always_comb begin
        hit      = 1'b0;
        data     = '0;
        slot_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_idx = head_ptr + PTR_W'(k);
            if (slot_match[slot_idx]) begin
                hit  = 1'b1;
                data = slot_wd[slot_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
//   Write-side initiator for the register file. Writeback requests from the
//   MEM/WB stage are buffered in an in-order queue of DEPTH entries and
//   drained one per cycle onto the regfile write port. Both read ports are
//   checked against still-queued writes.
//
//   Build option REGFILE_WB_FWD_EN:
//     defined   : rd_n returns the youngest queued data for ra_n, falling
//                 back to the raw regfile data; hazard_n is tied low.
//     undefined : rd_n is the raw regfile data; hazard_n flags a queued,
//                 not yet written register so decode can stall.
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid/in_ready     writeback request handshake
//     in_wa, in_wd          request address / data (wa==0 accepted, dropped)
//     drain_en              allow a regfile write this cycle
//     rf_regwrite/wa/wd     regfile write port (queue head, 0 when empty)
//     ra1, ra2              read addresses
//     rf_rd1, rf_rd2        raw regfile read data
//     rd1, rd2              resolved read data for decode
//     hazard1, hazard2      read port targets a queued register
//     pending               occupied queue entries
// ---------------------------------------------------------------------------
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_wa,
    input  logic [WIDTH-1:0]         in_wd,
    input  logic                     drain_en,
    output logic                     rf_regwrite,
    output logic [ADDR_W-1:0]        rf_wa,
    output logic [WIDTH-1:0]         rf_wd,
    input  logic [ADDR_W-1:0]        ra1,
    input  logic [ADDR_W-1:0]        ra2,
    input  logic [WIDTH-1:0]         rf_rd1,
    input  logic [WIDTH-1:0]         rf_rd2,
    output logic [WIDTH-1:0]         rd1,
    output logic [WIDTH-1:0]         rd2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_w(WIDTH, ADDR_W);

    logic [ADDR_W-1:0]        wa_q [DEPTH];
    logic [WIDTH-1:0]         wd_q [DEPTH];
    logic [DEPTH-1:0]         valid_q;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     full, empty, push, store, pop;
    logic [DEPTH*ENTRY_W-1:0] entries_flat;
    logic                     hit1, hit2;
    logic [WIDTH-1:0]         fwd_data1, fwd_data2;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    // Writes to r0 complete the handshake but never occupy an entry.
    assign store    = push && (in_wa != ADDR_W'(R0_ADDR));
    // No regfile write may leave the block while reset is asserted.
    assign pop      = !empty && drain_en && !rst;

    assign rf_regwrite = pop;
    assign rf_wa       = empty ? '0 : wa_q[rd_ptr_q];
    assign rf_wd       = empty ? '0 : wd_q[rd_ptr_q];
    assign pending     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (store && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !store) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Set and clear never hit the same slot: that needs a full queue
            // with a push, and push is blocked when full.
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (store) begin
                valid_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; occupancy lives in valid_q/count_q.
    always_ff @(posedge clk) begin
        if (store) begin
            wa_q[wr_ptr_q] <= in_wa;
            wd_q[wr_ptr_q] <= in_wd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pack
            assign entries_flat[gi*ENTRY_W +: ENTRY_W] = {wa_q[gi], wd_q[gi]};
        end
    endgenerate

    // The entry being popped this cycle is still matched: the regfile only
    // holds its data from the next cycle on.
    wb_fwd_match #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match1 (
        .ra          (ra1),
        .head_ptr    (rd_ptr_q),
        .entry_valid (valid_q),
        .entries     (entries_flat),
        .hit         (hit1),
        .data        (fwd_data1)
    );

    wb_fwd_match #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match2 (
        .ra          (ra2),
        .head_ptr    (rd_ptr_q),
        .entry_valid (valid_q),
        .entries     (entries_flat),
        .hit         (hit2),
        .data        (fwd_data2)
    );

`ifdef REGFILE_WB_FWD_EN
    assign rd1     = (ra1 == ADDR_W'(R0_ADDR)) ? '0 : (hit1 ? fwd_data1 : rf_rd1);
    assign rd2     = (ra2 == ADDR_W'(R0_ADDR)) ? '0 : (hit2 ? fwd_data2 : rf_rd2);
    assign hazard1 = 1'b0;
    assign hazard2 = 1'b0;
`else
    assign rd1     = (ra1 == ADDR_W'(R0_ADDR)) ? '0 : rf_rd1;
    assign rd2     = (ra2 == ADDR_W'(R0_ADDR)) ? '0 : rf_rd2;
    assign hazard1 = hit1;
    assign hazard2 = hit2;
    // Forwarded data is not consumed when decode stalls instead.
    logic unused_fwd_data;
    assign unused_fwd_data = ^{fwd_data1, fwd_data2};
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
//   Directed scenarios with hand-computed expectations, followed by a
//   randomised run, all checked against a queue reference model. Works with
//   and without REGFILE_WB_FWD_EN defined.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, drain_en, rf_regwrite, hazard1, hazard2;
    logic [4:0]  in_wa, rf_wa, ra1, ra2;
    logic [31:0] in_wd, rf_wd, rf_rd1, rf_rd2, rd1, rd2;
    logic [2:0]  pending;

    int checks   = 0;
    int failures = 0;

    // Reference queue, oldest at index 0, entries {wa, wd}.
    logic [36:0] mq[$];

    regfile_wb_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wa       (in_wa),
        .in_wd       (in_wd),
        .drain_en    (drain_en),
        .rf_regwrite (rf_regwrite),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .ra1         (ra1),
        .ra2         (ra2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .rd1         (rd1),
        .rd2         (rd2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .pending     (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [4:0] wa,
                         input logic [31:0] wd, input logic d,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d1, input logic [31:0] d2);
        rst = r; in_valid = v; in_wa = wa; in_wd = wd; drain_en = d;
        ra1 = a1; ra2 = a2; rf_rd1 = d1; rf_rd2 = d2;
        #1;
    endtask

    task automatic model_read(input logic [4:0] ra, input logic [31:0] rf,
                              output logic [31:0] rd, output logic hz);
        logic        found;
        logic [31:0] fd;
        found = 1'b0;
        fd    = '0;
        foreach (mq[i]) begin
            if (ra != 5'd0 && mq[i][36:32] == ra) begin
                found = 1'b1;
                fd    = mq[i][31:0];
            end
        end
`ifdef REGFILE_WB_FWD_EN
        rd = (ra == 5'd0) ? 32'd0 : (found ? fd : rf);
        hz = 1'b0;
`else
        rd = (ra == 5'd0) ? 32'd0 : rf;
        hz = found;
`endif
    endtask

    task automatic check_model(input string t);
        logic [31:0] e_rd;
        logic        e_hz;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        if (mq.size() != 0) begin
            e_wa = mq[0][36:32];
            e_wd = mq[0][31:0];
        end else begin
            e_wa = '0;
            e_wd = '0;
        end
        check({t, "_ready"},   32'(in_ready),    32'(!rst && mq.size() < 4));
        check({t, "_we"},      32'(rf_regwrite), 32'(!rst && mq.size() != 0 && drain_en));
        check({t, "_rfwa"},    32'(rf_wa),       32'(e_wa));
        check({t, "_rfwd"},    rf_wd,            e_wd);
        check({t, "_pending"}, 32'(pending),     32'(mq.size()));
        model_read(ra1, rf_rd1, e_rd, e_hz);
        check({t, "_rd1"},     rd1,              e_rd);
        check({t, "_hz1"},     32'(hazard1),     32'(e_hz));
        model_read(ra2, rf_rd2, e_rd, e_hz);
        check({t, "_rd2"},     rd2,              e_rd);
        check({t, "_hz2"},     32'(hazard2),     32'(e_hz));
    endtask

    task automatic tick();
        logic do_pop, do_push;
        do_pop  = !rst && drain_en && mq.size() != 0;
        do_push = !rst && in_valid && mq.size() < 4 && in_wa != 5'd0;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({in_wa, in_wd});
        end
        #1;
    endtask

    initial begin
        // Reset
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_we", 32'(rf_regwrite), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_model("t0");
        check("t0_ready", 32'(in_ready), 1);
        check("t0_pending", 32'(pending), 0);
        check("t0_we", 32'(rf_regwrite), 0);
        tick();

        // 1: single write, exactly one cycle to the regfile
        drive(0, 1, 5, 32'hA5A5_0001, 1, 5, 0, 32'h11, 32'h22);
        check_model("t1a");
        check("t1a_we", 32'(rf_regwrite), 0);
        tick();
        drive(0, 0, 0, 0, 1, 5, 0, 32'h11, 32'h22);
        check_model("t1b");
        check("t1b_we", 32'(rf_regwrite), 1);
        check("t1b_wa", 32'(rf_wa), 5);
        check("t1b_wd", rf_wd, 32'hA5A5_0001);
        check("t1b_pending", 32'(pending), 1);
`ifdef REGFILE_WB_FWD_EN
        check("t1b_rd1", rd1, 32'hA5A5_0001);
`else
        check("t1b_hz1", 32'(hazard1), 1);
        check("t1b_rd1", rd1, 32'h11);
`endif
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check_model("t1c");
        check("t1c_pending", 32'(pending), 0);
        tick();

        // 2: fill with four writes to r3, no draining
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 3, 32'(i), 0, 3, 0, 32'hDEAD, 0);
            check_model("t2fill");
            tick();
        end
        drive(0, 1, 3, 32'd5, 0, 3, 0, 32'hDEAD, 0);
        check_model("t2full");
        check("t2_ready", 32'(in_ready), 0);
        check("t2_pending", 32'(pending), 4);
`ifdef REGFILE_WB_FWD_EN
        check("t2_rd1", rd1, 32'd4);
`else
        check("t2_hz1", 32'(hazard1), 1);
        check("t2_rd1", rd1, 32'hDEAD);
`endif
        tick();

        // 3: drain from full while pushing; in-order 1,2,3,4 to r3
        drive(0, 1, 3, 32'd5, 1, 3, 3, 32'hDEAD, 32'hBEEF);
        check_model("t3c1");
        check("t3c1_ready", 32'(in_ready), 0);
        check("t3c1_we", 32'(rf_regwrite), 1);
        check("t3c1_wa", 32'(rf_wa), 3);
        check("t3c1_wd", rf_wd, 1);
        check("t3c1_pending", 32'(pending), 4);
        tick();
        drive(0, 1, 3, 32'd6, 1, 3, 3, 32'hDEAD, 32'hBEEF);
        check_model("t3c2");
        check("t3c2_ready", 32'(in_ready), 1);
        check("t3c2_wd", rf_wd, 2);
        check("t3c2_pending", 32'(pending), 3);
        tick();
        drive(0, 1, 3, 32'd7, 1, 3, 3, 32'hDEAD, 32'hBEEF);
        check_model("t3c3");
        check("t3c3_wd", rf_wd, 3);
        check("t3c3_pending", 32'(pending), 3);
`ifdef REGFILE_WB_FWD_EN
        check("t3c3_rd1", rd1, 32'd6);
`else
        check("t3c3_hz1", 32'(hazard1), 1);
`endif
        tick();
        drive(0, 0, 0, 0, 1, 3, 3, 32'hDEAD, 32'hBEEF);
        check_model("t3c4");
        check("t3c4_wd", rf_wd, 4);
        check("t3c4_pending", 32'(pending), 3);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 3, 0, 32'hDEAD, 0);
            check_model("t3drain");
            tick();
        end

        // 4: write to r0 is swallowed
        drive(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 32'h1234, 0);
        check_model("t4a");
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 32'h1234, 0);
        check_model("t4b");
        check("t4_pending", 32'(pending), 0);
        check("t4_we", 32'(rf_regwrite), 0);
        check("t4_rd1", rd1, 0);
        check("t4_hz1", 32'(hazard1), 0);
        tick();

        // 5: mid-operation reset discards three queued writes
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 5'(i), 32'h100 + 32'(i), 0, 2, 1, 32'h77, 32'h88);
            check_model("t5fill");
            tick();
        end
        drive(1, 0, 0, 0, 1, 2, 1, 32'h77, 32'h88);
        check_model("t5rst");
        check("t5rst_we", 32'(rf_regwrite), 0);
        check("t5rst_ready", 32'(in_ready), 0);
        check("t5rst_pending", 32'(pending), 3);
        tick();
        drive(0, 0, 0, 0, 1, 2, 1, 32'h77, 32'h88);
        check_model("t5post");
        check("t5_pending", 32'(pending), 0);
        check("t5_hz1", 32'(hazard1), 0);
        check("t5_hz2", 32'(hazard2), 0);
        check("t5_ready", 32'(in_ready), 1);
        check("t5_rd1", rd1, 32'h77);
        tick();

        // 6: randomised push/drain against the reference model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)),
                  $urandom,
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom);
            check_model("t6");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
